registradores_param: RTL
========================

REGISTRADORES_PARAM -- requirements
Module: registradores_param

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register and port data width; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 4, address width; register count NUM_REGS = 2**ADDR_WIDTH.
REQ-003 Parameter ZERO_REG, default 1, when 1 register 0 always reads 0 and ignores writes.
REQ-004 Clock_in  input  1  single clock; all state changes on rising edge except reset.
REQ-005 Signal_reset  input  1  asynchronous, active-low reset.
REQ-006 Read_1, Read_2  input  ADDR_WIDTH  read port addresses.
REQ-007 Address_to_write  input  ADDR_WIDTH  write address.
REQ-008 Data_to_write  input  DATA_WIDTH  write data.
REQ-009 Byte_enable  input  DATA_WIDTH/8  per-byte write mask, bit i covers bits 8i+7..8i.
REQ-010 Signal_write  input  1  write request.
REQ-011 Signal_read  input  1  read request.
REQ-012 Signal_clear  input  1  sequential clear-all request.
REQ-013 Out_1, Out_2  output  DATA_WIDTH  registered read data.
REQ-014 Out_valid  output  1  high one cycle after an accepted read.
REQ-015 Busy  output  1  high while clear sweep runs.

Function
REQ-016 Read accepted on an edge with Signal_read=1 and Busy=0; Out_1/Out_2 SHALL take reg[Read_1]/reg[Read_2] at that edge; latency 1 cycle.
REQ-017 Out_valid SHALL be 1 in the cycle after an accepted read, else 0; Out_1/Out_2 SHALL hold when no read accepted.
REQ-018 Write accepted on an edge with Signal_write=1, Busy=0, Signal_clear=0; only bytes with Byte_enable=1 updated.
REQ-019 ZERO_REG=1: write to address 0 discarded; reads of address 0 return 0.
REQ-020 Read and write to the same address on the same edge: read returns pre-write value (see REQ-031 for override).
REQ-021 FSM states IDLE, CLEAR; IDLE->CLEAR on Signal_clear=1 in IDLE; sweep counter starts at 0.
REQ-022 In CLEAR, one register per cycle zeroed, counter 0..NUM_REGS-1; after last, return to IDLE.
REQ-023 Busy SHALL be 1 for exactly NUM_REGS cycles, beginning the cycle after clear accepted.
REQ-024 While Busy=1, reads and writes ignored, Out_valid=0, Out_1/Out_2 hold; Signal_clear ignored.
REQ-025 Signal_clear and Signal_write on same IDLE edge: clear wins, write dropped; simultaneous read still accepted.
REQ-026 Counter wraps to 0 on return to IDLE; no overflow beyond NUM_REGS-1.

Reset
REQ-027 Signal_reset=0 SHALL immediately zero all registers, Out_1, Out_2, Out_valid, Busy, sweep counter; FSM to IDLE.
REQ-028 Reset during CLEAR aborts sweep; first edge after release is in IDLE and accepts requests.
REQ-029 Reset deassertion takes effect on the next rising edge; no request accepted on the edge coincident with release if Signal_reset still 0.

Configuration
REQ-030 Macro REGISTRADORES_FORWARDING_EN controls write-to-read bypass.
REQ-031 Defined: same-edge read and accepted write to same nonzero address return new value merged per Byte_enable; undefined: REQ-020 old-value behaviour.

Verification
REQ-032 Reset low 6 time units then high; read addr 0,1 -> Out_1=0, Out_2=0, Out_valid=1 next cycle.
REQ-033 Write 32'h1 to addr 3 full mask; read Read_1=3 -> Out_1=32'h1; write 32'hFF to addr 0 -> read addr 0 gives 0.
REQ-034 reg5=32'h11223344, write 32'hAABBCCDD Byte_enable=4'b0101 -> read gives 32'h11BB33DD.
REQ-035 Write 32'h7 to addr 7 and read addr 7 same edge -> Out_2=0 without macro, 32'h7 with macro; next read 32'h7 both.
REQ-036 Fill regs 1..15 nonzero, pulse Signal_clear -> Busy high exactly 16 cycles, writes during Busy dropped, then all reads 0.
REQ-037 Reset asserted on cycle 5 of clear sweep -> Busy=0 immediately, all outputs 0, write on first edge after release succeeds.

Source files
------------

// File: rtl/registradores_param.sv
// rtl/registradores_param.sv - parameterised register file with byte-masked writes and sequential clear
//
// Purpose:
//   NUM_REGS = 2**ADDR_WIDTH registers of DATA_WIDTH bits, two registered read
//   ports, one byte-masked write port and a one-register-per-cycle clear sweep.
//   With ZERO_REG=1, register 0 is hardwired to zero.
//
// Optional feature:
//   `define REGISTRADORES_FORWARDING_EN enables write-to-read bypass. With it,
//   a read on the same edge as an accepted write to the same address returns
//   the new byte-merged value. Without it, the read returns the pre-write value.
//
// Ports:
//   Clock_in          in   rising-edge clock
//   Signal_reset      in   asynchronous active-low reset
//   Read_1, Read_2    in   read addresses
//   Address_to_write  in   write address
//   Data_to_write     in   write data
//   Byte_enable       in   per-byte write mask, bit i covers bits 8i+7..8i
//   Signal_write      in   write request
//   Signal_read       in   read request
//   Signal_clear      in   start clear-all sweep
//   Out_1, Out_2      out  registered read data (held when no read is accepted)
//   Out_valid         out  high for one cycle after an accepted read
//   Busy              out  high while the clear sweep runs
module registradores_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int ZERO_REG   = 1
) (
  input  logic                    Clock_in,
  input  logic                    Signal_reset,
  input  logic [ADDR_WIDTH-1:0]   Read_1,
  input  logic [ADDR_WIDTH-1:0]   Read_2,
  input  logic [ADDR_WIDTH-1:0]   Address_to_write,
  input  logic [DATA_WIDTH-1:0]   Data_to_write,
  input  logic [DATA_WIDTH/8-1:0] Byte_enable,
  input  logic                    Signal_write,
  input  logic                    Signal_read,
  input  logic                    Signal_clear,
  output logic [DATA_WIDTH-1:0]   Out_1,
  output logic [DATA_WIDTH-1:0]   Out_2,
  output logic                    Out_valid,
  output logic                    Busy
);

  localparam int NUM_REGS  = 2 ** ADDR_WIDTH;
  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

  logic                    idle;
  logic                    read_ok;
  logic                    write_ok;
  logic                    write_hits;
  logic [DATA_WIDTH-1:0]   wr_merged;
  logic [DATA_WIDTH-1:0]   rd_1, rd_2;

  assign idle     = (state_q == IDLE);
  assign read_ok  = Signal_read && idle;
  // Clear takes priority over a write presented on the same edge.
  assign write_ok = Signal_write && idle && !Signal_clear;
  // A write only lands when it targets a real register (not the hardwired zero).
  assign write_hits = write_ok && !((ZERO_REG != 0) && (Address_to_write == '0));
  assign Busy     = (state_q == CLEAR);

  // Current contents of the write target with the enabled bytes replaced.
  always_comb begin
    wr_merged = regs[Address_to_write];
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (Byte_enable[b]) begin
        wr_merged[8*b +: 8] = Data_to_write[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_1 = regs[Read_1];
    rd_2 = regs[Read_2];
`ifdef REGISTRADORES_FORWARDING_EN
    if (write_hits && (Address_to_write == Read_1)) begin
      rd_1 = wr_merged;
    end
    if (write_hits && (Address_to_write == Read_2)) begin
      rd_2 = wr_merged;
    end
`endif
    if ((ZERO_REG != 0) && (Read_1 == '0)) begin
      rd_1 = '0;
    end
    if ((ZERO_REG != 0) && (Read_2 == '0)) begin
      rd_2 = '0;
    end
  end

  // Sweep FSM: one register is zeroed per CLEAR cycle, so Busy lasts NUM_REGS cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (Signal_clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clock_in or negedge Signal_reset) begin
    if (!Signal_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge Clock_in or negedge Signal_reset) begin
    if (!Signal_reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (state_q == CLEAR) begin
      regs[cnt_q] <= '0;
    end else if (write_hits) begin
      regs[Address_to_write] <= wr_merged;
    end
  end

  always_ff @(posedge Clock_in or negedge Signal_reset) begin
    if (!Signal_reset) begin
      Out_1     <= '0;
      Out_2     <= '0;
      Out_valid <= 1'b0;
    end else begin
      Out_valid <= read_ok;
      if (read_ok) begin
        Out_1 <= rd_1;
        Out_2 <= rd_2;
      end
    end
  end

endmodule
